// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Circular prefetch FIFO (fetch_queue) holding {pc, instruction} pairs.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  fetch_entry_t  mem [DEPTH];
  logic          do_pop;
  logic          do_push;

  // A push into a full queue is legal only when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues sequential fetches, queues responses, handles redirects.
// Optional perf counters are enabled with `define IFETCH_PERF_CNT_EN.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       inst_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          epoch;
  logic          inflight;
  logic          inflight_epoch;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  // The in-flight response already owns a queue slot, so it counts toward capacity.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req   = !reset && !redirect_valid && (occupancy < DEPTH_W);
  assign imem_addr  = fetch_pc;
  assign push       = inflight && (inflight_epoch == epoch) && !redirect_valid;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign wr_entry   = '{pc: inflight_pc, inst: imem_rdata};
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
      epoch    <= ~epoch;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc       <= fetch_pc + 32'(PC_STEP);
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(wr_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [32:0] fetched_sum;
  logic [32:0] flushed_sum;

  // Saturating counters; a redirect drops every queued entry plus any response in flight.
  assign fetched_sum = {1'b0, perf_fetched} + 33'(push);
  assign flushed_sum = {1'b0, perf_flushed} + 33'(count) + 33'(inflight);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      if (redirect_valid)
        perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a plain queue of pending instructions plus one outstanding fetch.
  logic [31:0] m_q_pc[$];
  logic [31:0] m_q_inst[$];
  logic [31:0] m_fetch_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed)
`endif
  );

  // Instruction memory: word = address / 4, garbage on idle cycles.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr >> 2) : $urandom();
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", tag, cyc, actual, expected);
    end
  endtask

  task automatic modelClear();
    m_q_pc.delete();
    m_q_inst.delete();
    m_fetch_pc = RESET_PC;
    m_inflight = 1'b0;
    m_inflight_pc = '0;
    m_fetched = '0;
    m_flushed = '0;
  endtask

  task automatic compareModel(input logic rv);
    logic exp_req;
    exp_req = !rv && ((m_q_pc.size() + int'(m_inflight)) < DEPTH);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    checkOutput("imem_addr", imem_addr, m_fetch_pc);
    checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, m_q_pc.size() > 0});
    if (m_q_pc.size() > 0) begin
      checkOutput("inst_pc", inst_pc, m_q_pc[0]);
      checkOutput("inst_out", inst_out, m_q_inst[0]);
    end
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("perf_fetched", perf_fetched, m_fetched);
    checkOutput("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  task automatic modelAdvance(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic req;
    if (rv) begin
      m_flushed += m_q_pc.size() + int'(m_inflight);
      m_q_pc.delete();
      m_q_inst.delete();
      m_inflight = 1'b0;
      m_fetch_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      req = (m_q_pc.size() + int'(m_inflight)) < DEPTH;
      if (rdy && m_q_pc.size() > 0) begin
        void'(m_q_pc.pop_front());
        void'(m_q_inst.pop_front());
      end
      if (m_inflight) begin
        m_q_pc.push_back(m_inflight_pc);
        m_q_inst.push_back(m_inflight_pc >> 2);
        m_fetched++;
      end
      m_inflight = req;
      if (req) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
    inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    compareModel(rv);
    modelAdvance(rdy, rv, rpc);
    @(negedge clk);
    cyc++;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst_out", inst_out, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    modelClear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    resetDut();

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b1, 1'b0, '0);

    for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 6; i++)  applyStimulus(1'b1, 1'b0, '0);

    applyStimulus(1'b1, 1'b1, 32'h0000_0043);
    for (int i = 0; i < 4; i++)  applyStimulus(1'b1, 1'b0, '0);

    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b1, 1'b0, '0);

    resetDut();
    for (int i = 0; i < 4; i++)  applyStimulus(1'b0, 1'b0, '0);
    resetDut();
    for (int i = 0; i < 6; i++)  applyStimulus(1'b1, 1'b0, '0);

    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      if ($urandom_range(0, 499) == 0) resetDut();
      else applyStimulus(rdy, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
